// File: rtl/fmul_operand_queue.sv
// -----------------------------------------------------------------------------
// fmul_operand_queue
//   Operand staging FIFO in front of the combinational floating-point
//   multiplier. Each (a,b) pair is classified when it is pushed. The class is
//   stored next to the operand, so the head pair and its class flags are
//   available straight from registers.
//
//   Optional feature macro: FMUL_OPQ_FTZ_EN
//     defined   : denormal operands are flushed to a signed zero at push and
//                 classed ZERO. The DENORM flag is never set.
//     undefined : operands are stored unchanged and denormals are flagged DENORM.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       synchronous reset, active low
//   in_valid_i   producer has an operand pair
//   in_ready_o   queue can accept a pair (= !full)
//   a_i, b_i     incoming operands, W = 1+EXP+MANT bits
//   out_valid_o  head entry valid (= !empty)
//   out_ready_i  consumer takes the head this cycle
//   a_o, b_o     head operands
//   a_class_o    head A class {NAN,INF,DENORM,ZERO}
//   b_class_o    head B class, same encoding
//   special_o    head pair needs a bypass result (any class bit set)
//   count_o      occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fmul_operand_queue #(
   parameter int EXP   = 8,
   parameter int MANT  = 23,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [EXP+MANT:0]          a_i,
   input  logic [EXP+MANT:0]          b_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [EXP+MANT:0]          a_o,
   output logic [EXP+MANT:0]          b_o,
   output logic [3:0]                 a_class_o,
   output logic [3:0]                 b_class_o,
   output logic                       special_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int W  = 1 + EXP + MANT;
   localparam int AW = $clog2(DEPTH);

   // The extra MSB on each pointer tells full apart from empty.
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_idx, rd_idx;

   logic [W-1:0]  a_mem_q     [DEPTH];
   logic [W-1:0]  b_mem_q     [DEPTH];
   logic [3:0]    a_cls_mem_q [DEPTH];
   logic [3:0]    b_cls_mem_q [DEPTH];

   logic          empty, full, push, pop;

   // Operand 0 is A and operand 1 is B. Both go through the same classifier.
   logic [W-1:0]  op_in  [2];
   logic [W-1:0]  op_st  [2];
   logic [3:0]    op_cls [2];

   assign op_in[0] = a_i;
   assign op_in[1] = b_i;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cls
         logic [EXP-1:0]  exp_f;
         logic [MANT-1:0] mant_f;
         logic            e_ones, e_zero, m_zero;

         assign exp_f  = op_in[gi][W-2 -: EXP];
         assign mant_f = op_in[gi][MANT-1:0];
         assign e_ones = &exp_f;
         assign e_zero = ~|exp_f;
         assign m_zero = ~|mant_f;

`ifdef FMUL_OPQ_FTZ_EN
         // Zero exponent covers both true zeros and denormals. Both leave as a
         // signed zero, which also normalises the mantissa of a true zero.
         assign op_st[gi]  = e_zero ? {op_in[gi][W-1], {(W-1){1'b0}}} : op_in[gi];
         assign op_cls[gi] = {e_ones & ~m_zero, e_ones & m_zero, 1'b0, e_zero};
`else
         assign op_st[gi]  = op_in[gi];
         assign op_cls[gi] = {e_ones & ~m_zero, e_ones & m_zero,
                              e_zero & ~m_zero, e_zero & m_zero};
`endif
      end
   endgenerate

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];

   // Status depends only on the registered pointers. A full queue refuses a
   // push even when a pop happens in the same cycle.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_ready_o  = ~full;
   assign out_valid_o = ~empty;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   // The pointer difference is modulo 2*DEPTH, so it is already 0..DEPTH.
   assign count_o = wr_ptr_q - rd_ptr_q;

   assign a_o       = a_mem_q[rd_idx];
   assign b_o       = b_mem_q[rd_idx];
   assign a_class_o = a_cls_mem_q[rd_idx];
   assign b_class_o = b_cls_mem_q[rd_idx];
   assign special_o = out_valid_o & ((|a_class_o) | (|b_class_o));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         // Storage is cleared so the head outputs read zero after reset.
         for (int i = 0; i < DEPTH; i++) begin
            a_mem_q[i]     <= '0;
            b_mem_q[i]     <= '0;
            a_cls_mem_q[i] <= '0;
            b_cls_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push) begin
            a_mem_q[wr_idx]     <= op_st[0];
            b_mem_q[wr_idx]     <= op_st[1];
            a_cls_mem_q[wr_idx] <= op_cls[0];
            b_cls_mem_q[wr_idx] <= op_cls[1];
         end
      end
   end

endmodule
